// File: rtl/mem_arb_pkg.sv
// Shared bus encodings and types for the unified-memory arbiter.
// Bus command values match the processor's sys_defs encoding.
package mem_arb_pkg;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam int MEM_ARB_TAG_W = 4;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_tag_table.sv
// Owner table for outstanding memory load tags: one {valid, owner} entry per tag.
// A set and a clear aimed at the same tag in one cycle leave the entry set with the new owner.
module mem_tag_table
  import mem_arb_pkg::*;
#(
  parameter int TAG_W = MEM_ARB_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set_en,
  input  logic [TAG_W-1:0] i_set_tag,
  input  owner_e           i_set_owner,
  input  logic [TAG_W-1:0] i_look_tag,
  input  logic             i_clr_en,
  output logic             o_hit,
  output owner_e           o_hit_owner,
  output logic             o_busy
);

  localparam int NENT = 1 << TAG_W;

  logic [NENT-1:0] r_valid;
  owner_e          r_owner [NENT];

  logic            w_look_nz;

  assign w_look_nz   = (i_look_tag != '0);
  assign o_hit       = w_look_nz && r_valid[i_look_tag];
  assign o_hit_owner = r_owner[i_look_tag];
  assign o_busy      = |r_valid;

  // The set is written after the clear so it wins on a same-tag collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < NENT; i++) begin
        r_owner[i] <= OWN_IF;
      end
    end else begin
      if (i_clr_en && w_look_nz) begin
        r_valid[i_look_tag] <= 1'b0;
      end
      if (i_set_en && (i_set_tag != '0)) begin
        r_valid[i_set_tag] <= 1'b1;
        r_owner[i_set_tag] <= i_set_owner;
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one unified memory between the fetch port and the data port, tracking
// the owner of every outstanding load tag so returns are routed back to it.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TAG_W      = MEM_ARB_TAG_W,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        im_command,
  input  logic [ADDR_W-1:0] im_addr,
  output logic [TAG_W-1:0]  im_response,
  output logic [DATA_W-1:0] im_data,
  output logic [TAG_W-1:0]  im_tag,
  input  logic [1:0]        dm_command,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [TAG_W-1:0]  dm_response,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [TAG_W-1:0]  dm_tag,
  output logic [1:0]        proc2mem_command,
  output logic [ADDR_W-1:0] proc2mem_addr,
  output logic [DATA_W-1:0] proc2mem_data,
  input  logic [TAG_W-1:0]  mem2proc_response,
  input  logic [DATA_W-1:0] mem2proc_data,
  input  logic [TAG_W-1:0]  mem2proc_tag,
  output logic              busy,
  output logic              err_orphan
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  // Handshake: a requester presents command/addr/data and holds them stable
  // until its *_response is non-zero; a zero response means retry next cycle.
  // A non-zero mem2proc_response is the memory's acceptance tag for the
  // command forwarded this cycle.

  logic [SW-1:0] r_starve_cnt;
  logic          r_err_orphan;

  logic          w_im_req;
  logic          w_dm_req;
  logic          w_grant_dm;
  logic          w_grant_im;
  logic          w_accept;
  logic          w_set_en;
  owner_e        w_set_owner;
  logic          w_hit;
  owner_e        w_hit_owner;
  logic          w_busy;
  logic          w_ret_nz;
  logic          w_orphan;

  assign w_im_req   = (im_command != BUS_NONE);
  assign w_dm_req   = (dm_command != BUS_NONE);
  assign w_grant_dm = w_dm_req && (!w_im_req || (r_starve_cnt < SMAX));
  assign w_grant_im = w_im_req && !w_grant_dm;

  assign w_accept    = rst && (mem2proc_response != '0);
  assign w_set_owner = w_grant_dm ? OWN_DM : OWN_IF;
  assign w_set_en    = w_accept &&
                       ((w_grant_dm && (dm_command == BUS_LOAD)) ||
                        (w_grant_im && (im_command == BUS_LOAD)));

  assign w_ret_nz = (mem2proc_tag != '0);
  assign w_orphan = w_ret_nz && !w_hit;

  mem_tag_table #(
    .TAG_W (TAG_W)
  ) u_tag_table (
    .clk         (clk),
    .rst_n       (rst),
    .i_set_en    (w_set_en),
    .i_set_tag   (mem2proc_response),
    .i_set_owner (w_set_owner),
    .i_look_tag  (mem2proc_tag),
    .i_clr_en    (w_hit),
    .o_hit       (w_hit),
    .o_hit_owner (w_hit_owner),
    .o_busy      (w_busy)
  );

  // Request path; every output is held at zero while reset is asserted.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    im_response      = '0;
    dm_response      = '0;
    if (rst) begin
      if (w_grant_dm) begin
        proc2mem_command = dm_command;
        proc2mem_addr    = dm_addr;
        proc2mem_data    = dm_wdata;
        dm_response      = mem2proc_response;
      end else if (w_grant_im) begin
        proc2mem_command = im_command;
        proc2mem_addr    = im_addr;
        im_response      = mem2proc_response;
      end
    end
  end

  // Return path: routed from the entry as it stood before this cycle's update.
  always_comb begin
    im_data  = '0;
    im_tag   = '0;
    dm_rdata = '0;
    dm_tag   = '0;
    if (rst && w_hit) begin
      if (w_hit_owner == OWN_DM) begin
        dm_rdata = mem2proc_data;
        dm_tag   = mem2proc_tag;
      end else begin
        im_data = mem2proc_data;
        im_tag  = mem2proc_tag;
      end
    end
  end

  // Fetch is starved only while it is actually waiting behind data grants.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (w_grant_dm && w_im_req) begin
      if (r_starve_cnt < SMAX) begin
        r_starve_cnt <= r_starve_cnt + SW'(1);
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_orphan <= 1'b0;
    end else if (w_orphan) begin
      r_err_orphan <= 1'b1;
    end
  end

  assign busy       = rst && w_busy;
  assign err_orphan = rst && r_err_orphan;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: fetch/data loads, stores, starvation
// pattern, same-tag collision, orphan returns and asynchronous reset.
module tb_unified_mem_arbiter;

  localparam int TAG_W  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] B_NONE  = 2'h0;
  localparam logic [1:0] B_LOAD  = 2'h1;
  localparam logic [1:0] B_STORE = 2'h2;

  logic              clk;
  logic              rst;
  logic [1:0]        im_command;
  logic [ADDR_W-1:0] im_addr;
  logic [TAG_W-1:0]  im_response;
  logic [DATA_W-1:0] im_data;
  logic [TAG_W-1:0]  im_tag;
  logic [1:0]        dm_command;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [TAG_W-1:0]  dm_response;
  logic [DATA_W-1:0] dm_rdata;
  logic [TAG_W-1:0]  dm_tag;
  logic [1:0]        proc2mem_command;
  logic [ADDR_W-1:0] proc2mem_addr;
  logic [DATA_W-1:0] proc2mem_data;
  logic [TAG_W-1:0]  mem2proc_response;
  logic [DATA_W-1:0] mem2proc_data;
  logic [TAG_W-1:0]  mem2proc_tag;
  logic              busy;
  logic              err_orphan;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] exp_q[$];

  unified_mem_arbiter #(
    .TAG_W      (TAG_W),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .im_command        (im_command),
    .im_addr           (im_addr),
    .im_response       (im_response),
    .im_data           (im_data),
    .im_tag            (im_tag),
    .dm_command        (dm_command),
    .dm_addr           (dm_addr),
    .dm_wdata          (dm_wdata),
    .dm_response       (dm_response),
    .dm_rdata          (dm_rdata),
    .dm_tag            (dm_tag),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .busy              (busy),
    .err_orphan        (err_orphan)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_im(input logic [1:0] cmd, input logic [31:0] addr);
    im_command = cmd;
    im_addr    = addr;
  endtask

  task automatic drive_dm(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wdata);
    dm_command = cmd;
    dm_addr    = addr;
    dm_wdata   = wdata;
  endtask

  task automatic drive_mem(input logic [3:0] resp, input logic [3:0] tag, input logic [31:0] data);
    mem2proc_response = resp;
    mem2proc_tag      = tag;
    mem2proc_data     = data;
  endtask

  task automatic idle_all();
    drive_im(B_NONE, 32'h0);
    drive_dm(B_NONE, 32'h0, 32'h0);
    drive_mem(4'h0, 4'h0, 32'h0);
  endtask

  // Pops expected grant (STORE = data, LOAD = fetch) and checks the request path.
  task automatic check_grant(input string tag, input logic [3:0] resp);
    logic [1:0] g;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd0, 32'd1);
      return;
    end
    g = exp_q.pop_front();
    check({tag, "_cmd"}, 32'(proc2mem_command), 32'(g));
    check({tag, "_addr"}, proc2mem_addr, (g == B_STORE) ? 32'h300 : 32'h200);
    check({tag, "_im_rsp"}, 32'(im_response), (g == B_LOAD) ? 32'(resp) : 32'h0);
    check({tag, "_dm_rsp"}, 32'(dm_response), (g == B_STORE) ? 32'(resp) : 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    idle_all();

    // Outputs stay zero under reset even with a live request and response.
    drive_im(B_LOAD, 32'h40);
    drive_mem(4'h3, 4'h3, 32'hFFFF_FFFF);
    #1;
    check("rst_cmd", 32'(proc2mem_command), 32'(B_NONE));
    check("rst_addr", proc2mem_addr, 32'h0);
    check("rst_im_rsp", 32'(im_response), 32'h0);
    check("rst_im_tag", 32'(im_tag), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err_orphan), 32'h0);
    idle_all();
    step();
    step();
    @(negedge clk);
    rst = 1'b1;
    step();

    // Fetch-only load accepted with tag 3, then returned.
    drive_im(B_LOAD, 32'h40);
    drive_mem(4'h3, 4'h0, 32'h0);
    #1;
    check("f_cmd", 32'(proc2mem_command), 32'(B_LOAD));
    check("f_addr", proc2mem_addr, 32'h40);
    check("f_im_rsp", 32'(im_response), 32'h3);
    check("f_dm_rsp", 32'(dm_response), 32'h0);
    step();
    idle_all();
    #1;
    check("f_busy", 32'(busy), 32'h1);
    drive_mem(4'h0, 4'h3, 32'h00A00093);
    #1;
    check("f_ret_tag", 32'(im_tag), 32'h3);
    check("f_ret_data", im_data, 32'h00A00093);
    check("f_ret_dm_tag", 32'(dm_tag), 32'h0);
    check("f_ret_dm_data", dm_rdata, 32'h0);
    step();
    idle_all();
    #1;
    check("f_busy_clr", 32'(busy), 32'h0);
    check("f_no_err", 32'(err_orphan), 32'h0);

    // Data store accepted with tag 5: forwarded, no table entry.
    drive_dm(B_STORE, 32'h100, 32'hDEADBEEF);
    drive_mem(4'h5, 4'h0, 32'h0);
    #1;
    check("st_cmd", 32'(proc2mem_command), 32'(B_STORE));
    check("st_addr", proc2mem_addr, 32'h100);
    check("st_data", proc2mem_data, 32'hDEADBEEF);
    check("st_dm_rsp", 32'(dm_response), 32'h5);
    check("st_im_rsp", 32'(im_response), 32'h0);
    step();
    idle_all();
    #1;
    check("st_busy", 32'(busy), 32'h0);

    // Both request every cycle: D,D,D,D,I repeating.
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(B_STORE);
      exp_q.push_back(B_STORE);
      exp_q.push_back(B_STORE);
      exp_q.push_back(B_STORE);
      exp_q.push_back(B_LOAD);
    end
    drive_im(B_LOAD, 32'h200);
    drive_dm(B_STORE, 32'h300, 32'h1234);
    drive_mem(4'h1, 4'h0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      #1;
      check_grant($sformatf("starve%0d", k), 4'h1);
      step();
    end
    idle_all();
    drive_mem(4'h0, 4'h1, 32'hCAFE0001);
    #1;
    check("starve_drain_tag", 32'(im_tag), 32'h1);
    step();
    idle_all();
    #1;
    check("starve_busy", 32'(busy), 32'h0);

    // Same-tag collision: fetch owns tag 2; data load accepted as tag 2 while tag 2 returns.
    drive_im(B_LOAD, 32'h44);
    drive_mem(4'h2, 4'h0, 32'h0);
    #1;
    check("col_im_rsp", 32'(im_response), 32'h2);
    step();
    idle_all();
    drive_dm(B_LOAD, 32'h80, 32'h0);
    drive_mem(4'h2, 4'h2, 32'h11);
    #1;
    check("col_dm_rsp", 32'(dm_response), 32'h2);
    check("col_im_tag", 32'(im_tag), 32'h2);
    check("col_im_data", im_data, 32'h11);
    check("col_dm_tag", 32'(dm_tag), 32'h0);
    step();
    idle_all();
    #1;
    check("col_busy", 32'(busy), 32'h1);
    drive_mem(4'h0, 4'h2, 32'h22);
    #1;
    check("col2_dm_tag", 32'(dm_tag), 32'h2);
    check("col2_dm_data", dm_rdata, 32'h22);
    check("col2_im_tag", 32'(im_tag), 32'h0);
    step();
    idle_all();
    #1;
    check("col2_busy", 32'(busy), 32'h0);
    check("col2_err", 32'(err_orphan), 32'h0);

    // Orphan return of tag 7.
    drive_mem(4'h0, 4'h7, 32'h77);
    #1;
    check("orph_im_tag", 32'(im_tag), 32'h0);
    check("orph_dm_tag", 32'(dm_tag), 32'h0);
    check("orph_im_data", im_data, 32'h0);
    step();
    idle_all();
    #1;
    check("orph_err", 32'(err_orphan), 32'h1);
    step();
    step();
    check("orph_sticky", 32'(err_orphan), 32'h1);

    // Three data loads outstanding while fetch waits, then async reset mid-cycle.
    drive_im(B_LOAD, 32'h500);
    drive_dm(B_LOAD, 32'h400, 32'h0);
    drive_mem(4'h4, 4'h0, 32'h0);
    #1;
    check("rl_dm_rsp4", 32'(dm_response), 32'h4);
    step();
    drive_dm(B_LOAD, 32'h404, 32'h0);
    drive_mem(4'h5, 4'h0, 32'h0);
    step();
    drive_dm(B_LOAD, 32'h408, 32'h0);
    drive_mem(4'h6, 4'h0, 32'h0);
    step();
    check("rl_busy", 32'(busy), 32'h1);
    drive_mem(4'h0, 4'h4, 32'h4444);
    #1;
    check("rl_ret4", 32'(dm_tag), 32'h4);
    rst = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_err", 32'(err_orphan), 32'h0);
    check("ar_cmd", 32'(proc2mem_command), 32'(B_NONE));
    check("ar_dm_tag", 32'(dm_tag), 32'h0);
    check("ar_dm_data", dm_rdata, 32'h0);
    check("ar_dm_rsp", 32'(dm_response), 32'h0);
    drive_mem(4'h0, 4'h0, 32'h0);
    drive_dm(B_STORE, 32'h300, 32'h0);
    drive_im(B_LOAD, 32'h200);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_busy", 32'(busy), 32'h0);
    // Starve counter restarts at zero: four data grants before fetch.
    exp_q.delete();
    exp_q.push_back(B_STORE);
    exp_q.push_back(B_STORE);
    exp_q.push_back(B_STORE);
    exp_q.push_back(B_STORE);
    exp_q.push_back(B_LOAD);
    for (int k = 0; k < 5; k++) begin
      check_grant($sformatf("post%0d", k), 4'h0);
      step();
    end
    idle_all();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=0x%08h exp=0x%08h", 32'd0, 32'd1);
    $fatal(1, "timeout");
  end

endmodule
